// File: rtl/riscv_ctrl_pkg.sv
// ============================================================================
// riscv_ctrl_pkg : shared encodings for the multi-cycle RV32I controller
// Rev 1.0
// ============================================================================
`default_nettype none

package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   function automatic logic [1:0] imm_src(input logic [6:0] opcode);
      case (opcode)
         OP_STORE:  return IMM_S;
         OP_BRANCH: return IMM_B;
         OP_JAL:    return IMM_J;
         default:   return IMM_I;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_decoder.sv
// ============================================================================
// alu_decoder : maps ALUOp / funct fields to the ALU operation select
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  aluop_t      aluop_i,
   input  logic [2:0]  funct3_i,
   input  logic        funct7b5_i,
   input  logic        op5_i,
   output logic [2:0]  alu_control_o
);

   always_comb begin
      alu_control_o = ALU_ADD;
      case (aluop_i)
         ALUOP_ADD: alu_control_o = ALU_ADD;
         ALUOP_SUB: alu_control_o = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3_i)
               // op5 separates R-type from I-type: addi never subtracts
               3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control_o = ALU_SLT;
               3'b100:  alu_control_o = ALU_XOR;
               3'b110:  alu_control_o = ALU_OR;
               3'b111:  alu_control_o = ALU_AND;
               default: alu_control_o = ALU_ADD;
            endcase
         end
         default: alu_control_o = ALU_ADD;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mc_controller.sv
// ============================================================================
// mc_controller : main sequencing FSM of the multi-cycle RV32I core
// Rev 1.0
// ============================================================================
`default_nettype none

module mc_controller
   import riscv_ctrl_pkg::*;
#(
   parameter bit MEM_WAIT_EN = 1'b1
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  OPcode,
   input  logic [2:0]  Funct3,
   input  logic        Funct7b5,
   input  logic        Zero,
   input  logic        MemReady,
   output logic        PCWrite,
   output logic        AdrSrc,
   output logic        MemWrite,
   output logic        IRWrite,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ImmSrc,
   output logic [2:0]  ALUControl,
   output logic        RegWrite,
   output logic        IllegalInstr
);

   state_t state_q, state_d;
   aluop_t aluop;
   logic   mem_rdy;

   generate
      if (MEM_WAIT_EN) begin : g_mem_wait
         assign mem_rdy = MemReady;
      end else begin : g_no_wait
         assign mem_rdy = 1'b1;
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d      = S_FETCH;
      PCWrite      = 1'b0;
      AdrSrc       = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      ResultSrc    = RES_ALUOUT;
      ALUSrcA      = SRCA_PC;
      ALUSrcB      = SRCB_RS2;
      aluop        = ALUOP_ADD;
      RegWrite     = 1'b0;
      IllegalInstr = 1'b0;
      case (state_q)
         S_FETCH: begin
            ResultSrc = RES_ALURESULT;
            ALUSrcB   = SRCB_FOUR;
            // reset holds state at FETCH, so the loads must be gated explicitly
            IRWrite   = mem_rdy & reset;
            PCWrite   = mem_rdy & reset;
            state_d   = mem_rdy ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            case (OPcode)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECUTER;
               OP_ITYPE:          state_d = S_EXECUTEI;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               default: begin
                  IllegalInstr = 1'b1;
                  state_d      = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            if (OPcode == OP_STORE)     state_d = S_MEMWRITE;
            else if (OPcode == OP_LOAD) state_d = S_MEMREAD;
            else                        state_d = S_FETCH;
         end
         S_MEMREAD: begin
            AdrSrc  = 1'b1;
            state_d = mem_rdy ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            RegWrite  = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
            state_d  = mem_rdy ? S_FETCH : S_MEMWRITE;
         end
         S_EXECUTER: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_RS2;
            aluop   = ALUOP_FUNCT;
            state_d = S_ALUWB;
         end
         S_EXECUTEI: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            aluop   = ALUOP_FUNCT;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            RegWrite = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_RS2;
            aluop   = ALUOP_SUB;
            // only beq/bne are resolved; other branch funct3 values never redirect
            if (Funct3[2:1] == 2'b00) PCWrite = Zero ^ Funct3[0];
         end
         S_JAL: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_FOUR;
            PCWrite = 1'b1;
            state_d = S_ALUWB;
         end
         default: state_d = S_FETCH;
      endcase
   end

   assign ImmSrc = imm_src(OPcode);

   alu_decoder u_alu_decoder (
      .aluop_i       (aluop),
      .funct3_i      (Funct3),
      .funct7b5_i    (Funct7b5),
      .op5_i         (OPcode[5]),
      .alu_control_o (ALUControl)
   );

endmodule

`default_nettype wire

// File: tb/tb_mc_controller.sv
// ============================================================================
// tb_mc_controller : directed cycle-by-cycle check of the controller outputs
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mc_controller;

   logic        clk;
   logic        reset;
   logic [6:0]  OPcode;
   logic [2:0]  Funct3;
   logic        Funct7b5;
   logic        Zero;
   logic        MemReady;
   logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalInstr;
   logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0]  ALUControl;

   int n_checks;
   int n_errors;

   mc_controller #(.MEM_WAIT_EN(1'b1)) dut (
      .clk          (clk),
      .reset        (reset),
      .OPcode       (OPcode),
      .Funct3       (Funct3),
      .Funct7b5     (Funct7b5),
      .Zero         (Zero),
      .MemReady     (MemReady),
      .PCWrite      (PCWrite),
      .AdrSrc       (AdrSrc),
      .MemWrite     (MemWrite),
      .IRWrite      (IRWrite),
      .ResultSrc    (ResultSrc),
      .ALUSrcA      (ALUSrcA),
      .ALUSrcB      (ALUSrcB),
      .ImmSrc       (ImmSrc),
      .ALUControl   (ALUControl),
      .RegWrite     (RegWrite),
      .IllegalInstr (IllegalInstr)
   );

   // {ImmSrc, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, RegWrite, IllegalInstr}
   logic [16:0] obs;
   assign obs = {ImmSrc, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                 ALUControl, RegWrite, IllegalInstr};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [16:0] ev(input logic [1:0] imm, input logic pcw, input logic adr,
                                      input logic mw, input logic irw, input logic [1:0] rs,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [2:0] alu, input logic rw, input logic ill);
      return {imm, pcw, adr, mw, irw, rs, sa, sb, alu, rw, ill};
   endfunction

   function automatic logic [16:0] v_fetch(input logic [1:0] imm, input logic rdy);
      return ev(imm, rdy, 1'b0, 1'b0, rdy, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0, 1'b0);
   endfunction
   function automatic logic [16:0] v_dec(input logic [1:0] imm, input logic ill);
      return ev(imm, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, 1'b0, ill);
   endfunction
   function automatic logic [16:0] v_wb(input logic [1:0] imm, input logic [1:0] rs);
      return ev(imm, 1'b0, 1'b0, 1'b0, 1'b0, rs, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0);
   endfunction
   function automatic logic [16:0] v_memadr(input logic [1:0] imm);
      return ev(imm, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 1'b0, 1'b0);
   endfunction
   function automatic logic [16:0] v_exec(input logic [1:0] sb, input logic [2:0] alu);
      return ev(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, sb, alu, 1'b0, 1'b0);
   endfunction
   function automatic logic [16:0] v_branch(input logic pcw);
      return ev(2'b10, pcw, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 1'b0, 1'b0);
   endfunction

   task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %05h expected %05h", tag, got, exp);
      end
   endtask

   task automatic set_ir(input logic [31:0] ir);
      OPcode   = ir[6:0];
      Funct3   = ir[14:12];
      Funct7b5 = ir[30];
   endtask

   task automatic step(input string tag, input logic rdy, input logic z, input logic [16:0] exp);
      @(negedge clk);
      MemReady = rdy;
      Zero     = z;
      #1;
      chk(tag, obs, exp);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset    = 1'b0;
      MemReady = 1'b0;
      Zero     = 1'b0;
      set_ir(32'h002081B3);

      @(negedge clk);
      MemReady = 1'b1;
      #1;
      chk("reset_state", obs, v_fetch(2'b00, 1'b0));
      MemReady = 1'b0;
      reset    = 1'b1;
      step("release_stall", 1'b0, 1'b0, v_fetch(2'b00, 1'b0));

      // add x3,x1,x2
      step("add_fetch",  1'b1, 1'b0, v_fetch(2'b00, 1'b1));
      step("add_decode", 1'b1, 1'b0, v_dec(2'b00, 1'b0));
      step("add_execr",  1'b1, 1'b0, v_exec(2'b00, 3'b000));
      step("add_aluwb",  1'b1, 1'b0, v_wb(2'b00, 2'b00));

      // sub x3,x1,x2
      set_ir(32'h402081B3);
      step("sub_fetch",  1'b1, 1'b0, v_fetch(2'b00, 1'b1));
      step("sub_decode", 1'b1, 1'b0, v_dec(2'b00, 1'b0));
      step("sub_execr",  1'b1, 1'b0, v_exec(2'b00, 3'b001));
      step("sub_aluwb",  1'b1, 1'b0, v_wb(2'b00, 2'b00));

      // addi x1,x1,0x400 (IR[30]=1 must not turn into sub)
      set_ir(32'h40008093);
      step("addi_fetch", 1'b1, 1'b0, v_fetch(2'b00, 1'b1));
      step("addi_decode",1'b1, 1'b0, v_dec(2'b00, 1'b0));
      step("addi_execi", 1'b1, 1'b0, v_exec(2'b01, 3'b000));
      step("addi_aluwb", 1'b1, 1'b0, v_wb(2'b00, 2'b00));

      // xori x1,x1,1
      set_ir(32'h0010C093);
      step("xori_fetch", 1'b1, 1'b0, v_fetch(2'b00, 1'b1));
      step("xori_decode",1'b1, 1'b0, v_dec(2'b00, 1'b0));
      step("xori_execi", 1'b1, 1'b0, v_exec(2'b01, 3'b100));
      step("xori_aluwb", 1'b1, 1'b0, v_wb(2'b00, 2'b00));

      // lw x5,0(x1) with three wait cycles in MEMREAD
      set_ir(32'h0000A283);
      step("lw_fetch",   1'b1, 1'b0, v_fetch(2'b00, 1'b1));
      step("lw_decode",  1'b1, 1'b0, v_dec(2'b00, 1'b0));
      step("lw_memadr",  1'b1, 1'b0, v_memadr(2'b00));
      for (int i = 0; i < 3; i++)
         step("lw_memread_wait", 1'b0, 1'b0,
              ev(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
      step("lw_memread_done", 1'b1, 1'b0,
           ev(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
      step("lw_memwb",   1'b1, 1'b0, v_wb(2'b00, 2'b01));

      // beq, Zero=1 -> taken
      set_ir(32'h00208063);
      step("beq_fetch",  1'b1, 1'b1, v_fetch(2'b10, 1'b1));
      step("beq_decode", 1'b1, 1'b1, v_dec(2'b10, 1'b0));
      step("beq_branch", 1'b1, 1'b1, v_branch(1'b1));

      // bne, Zero=1 -> not taken
      set_ir(32'h00209063);
      step("bne_fetch",  1'b1, 1'b1, v_fetch(2'b10, 1'b1));
      step("bne_decode", 1'b1, 1'b1, v_dec(2'b10, 1'b0));
      step("bne_branch", 1'b1, 1'b1, v_branch(1'b0));

      // blt is not resolved here: never taken even with Zero=1
      set_ir(32'h0020C063);
      step("blt_fetch",  1'b1, 1'b1, v_fetch(2'b10, 1'b1));
      step("blt_decode", 1'b1, 1'b1, v_dec(2'b10, 1'b0));
      step("blt_branch", 1'b1, 1'b1, v_branch(1'b0));

      // jal x1,0
      set_ir(32'h000000EF);
      step("jal_fetch",  1'b1, 1'b0, v_fetch(2'b11, 1'b1));
      step("jal_decode", 1'b1, 1'b0, v_dec(2'b11, 1'b0));
      step("jal_jal",    1'b1, 1'b0,
           ev(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, 1'b0, 1'b0));
      step("jal_aluwb",  1'b1, 1'b0, v_wb(2'b11, 2'b00));

      // sw x5,0(x1) with one wait cycle
      set_ir(32'h0050A023);
      step("sw_fetch",   1'b1, 1'b0, v_fetch(2'b01, 1'b1));
      step("sw_decode",  1'b1, 1'b0, v_dec(2'b01, 1'b0));
      step("sw_memadr",  1'b1, 1'b0, v_memadr(2'b01));
      step("sw_memwrite_wait", 1'b0, 1'b0,
           ev(2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
      step("sw_memwrite_done", 1'b1, 1'b0,
           ev(2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
      step("sw_next_fetch", 1'b0, 1'b0, v_fetch(2'b01, 1'b0));

      // sw interrupted by reset mid-MEMWRITE
      step("swr_fetch",  1'b1, 1'b0, v_fetch(2'b01, 1'b1));
      step("swr_decode", 1'b1, 1'b0, v_dec(2'b01, 1'b0));
      step("swr_memadr", 1'b1, 1'b0, v_memadr(2'b01));
      step("swr_memwrite", 1'b0, 1'b0,
           ev(2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
      #1;
      reset    = 1'b0;
      MemReady = 1'b1;
      #1;
      chk("swr_reset_async", obs, v_fetch(2'b01, 1'b0));
      @(negedge clk);
      #1;
      chk("swr_reset_held", obs, v_fetch(2'b01, 1'b0));
      @(negedge clk);
      MemReady = 1'b0;
      reset    = 1'b1;
      #1;
      chk("swr_release", obs, v_fetch(2'b01, 1'b0));
      step("swr_stall", 1'b0, 1'b0, v_fetch(2'b01, 1'b0));

      // unsupported opcode 0x7F
      set_ir(32'h0000007F);
      step("ill_fetch",  1'b1, 1'b0, v_fetch(2'b00, 1'b1));
      step("ill_decode", 1'b1, 1'b0, v_dec(2'b00, 1'b1));
      step("ill_next",   1'b0, 1'b0, v_fetch(2'b00, 1'b0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
